// File: rtl/neighbourhood_window.sv
// neighbourhood_window
//   Consumer end of the multitap line buffer. Each accepted raster pixel arrives as
//   NUM_TAPS vertically stacked taps. The block shifts them into a NUM_TAPS x WINDOW_COLS
//   column store and tracks the raster position of the incoming pixel. For every fully
//   populated position it emits one registered window, one cycle after the pixel.
//
// Ports
//   clk            clock
//   reset          synchronous active-high; also latches r_width / r_height
//   r_width        row length in pixels (0 means 2^COORD_BITS), sampled during reset
//   r_height       frame height in rows (0 means 2^COORD_BITS), sampled during reset
//   in_valid       in_taps carries a pixel this cycle
//   in_taps        tap k = pixel (in_x, in_y-1-k)
//   out_valid      window outputs valid this cycle
//   out_window     [r][c]; r=0 top (oldest) row, c=0 leftmost column
//   out_x          column of the window's left edge
//   out_y          row of the window's top edge
//   out_frame_end  last window of the frame
module neighbourhood_window #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned NUM_TAPS    = 3,
  parameter int unsigned WINDOW_COLS = 3,
  parameter int unsigned COORD_BITS  = 8
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [COORD_BITS-1:0]                                r_width,
  input  logic [COORD_BITS-1:0]                                r_height,
  input  logic                                                 in_valid,
  input  logic [NUM_TAPS-1:0][DATA_BITS-1:0]                   in_taps,
  output logic                                                 out_valid,
  output logic [NUM_TAPS-1:0][WINDOW_COLS-1:0][DATA_BITS-1:0]  out_window,
  output logic [COORD_BITS-1:0]                                out_x,
  output logic [COORD_BITS-1:0]                                out_y,
  output logic                                                 out_frame_end
);

  localparam logic [COORD_BITS-1:0] FirstRow = COORD_BITS'(NUM_TAPS);
  localparam logic [COORD_BITS-1:0] FirstCol = COORD_BITS'(WINDOW_COLS - 1);
  localparam logic [COORD_BITS-1:0] One      = COORD_BITS'(1);

  typedef logic [NUM_TAPS-1:0][WINDOW_COLS-1:0][DATA_BITS-1:0] window_t;

  // Frame geometry, latched during reset
  logic [COORD_BITS-1:0] width_q, height_q;

  // Raster position of the pixel presented on in_taps
  logic [COORD_BITS-1:0] in_x_q, in_x_d;
  logic [COORD_BITS-1:0] in_y_q, in_y_d;

  // Column store
  window_t win_q, win_d;

  // Output registers
  logic                  out_valid_q, out_valid_d;
  logic                  out_frame_end_q, out_frame_end_d;
  window_t               out_window_q, out_window_d;
  logic [COORD_BITS-1:0] out_x_q, out_x_d;
  logic [COORD_BITS-1:0] out_y_q, out_y_d;

  logic last_col, last_row, qualify;

  // A zero dimension wraps to all-ones here, giving the 2^COORD_BITS behaviour for free.
  assign last_col = (in_x_q == width_q - One);
  assign last_row = (in_y_q == height_q - One);

  // Requiring in_x >= WINDOW_COLS-1 guarantees every column in the store belongs to
  // the current row, so leftovers from the previous row are never emitted.
  assign qualify = in_valid && (in_y_q >= FirstRow) && (in_x_q >= FirstCol);

  // Raster counters
  always_comb begin
    in_x_d = in_x_q;
    in_y_d = in_y_q;
    if (in_valid) begin
      if (last_col) begin
        in_x_d = '0;
        in_y_d = last_row ? '0 : in_y_q + One;
      end else begin
        in_x_d = in_x_q + One;
      end
    end
  end

  // Column store: shift left, newest column enters on the right. Row 0 is the oldest
  // row, which is the deepest tap.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < int'(NUM_TAPS); r++) begin
        for (int c = 0; c < int'(WINDOW_COLS) - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WINDOW_COLS-1] = in_taps[NUM_TAPS-1-r];
      end
    end
  end

  // Output next-state; window and coordinates hold when nothing qualifies
  always_comb begin
    out_valid_d     = qualify;
    out_frame_end_d = qualify && last_col && last_row;
    out_window_d    = out_window_q;
    out_x_d         = out_x_q;
    out_y_d         = out_y_q;
    if (qualify) begin
      out_window_d = win_d;
      out_x_d      = in_x_q - FirstCol;
      out_y_d      = in_y_q - FirstRow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      width_q         <= r_width;
      height_q        <= r_height;
      in_x_q          <= '0;
      in_y_q          <= '0;
      win_q           <= '0;
      out_valid_q     <= 1'b0;
      out_frame_end_q <= 1'b0;
      out_window_q    <= '0;
      out_x_q         <= '0;
      out_y_q         <= '0;
    end else begin
      in_x_q          <= in_x_d;
      in_y_q          <= in_y_d;
      win_q           <= win_d;
      out_valid_q     <= out_valid_d;
      out_frame_end_q <= out_frame_end_d;
      out_window_q    <= out_window_d;
      out_x_q         <= out_x_d;
      out_y_q         <= out_y_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_frame_end = out_frame_end_q;
  assign out_window    = out_window_q;
  assign out_x         = out_x_q;
  assign out_y         = out_y_q;

endmodule
